edge_detector_multi: RTL and testbench

EDGE_DETECTOR_MULTI -- requirements
Module: edge_detector_multi

---
 rtl/edge_pkg.sv | 17 +
 rtl/edge_detector_multi_if.sv | 21 ++
 rtl/edge_chan.sv | 69 ++++++
 rtl/edge_detector_multi.sv | 42 ++++
 tb/tb_edge_detector_multi.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared mode encodings and edge/mode matching helper
package edge_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // True when an accepted level change in the given direction should be reported.
   function automatic logic mode_allows(input logic [1:0] mode, input logic rising);
      if (rising) begin
         return (mode == MODE_RISE) || (mode == MODE_BOTH);
      end
      return (mode == MODE_FALL) || (mode == MODE_BOTH);
   endfunction

endpackage

// File: rtl/edge_detector_multi_if.sv
// rtl/edge_detector_multi_if.sv - channel bundle: raw inputs, mode, clear and filtered/event outputs
interface edge_detector_multi_if #(
   parameter int W = 1
);
   logic [W-1:0]   sig_in;
   logic [2*W-1:0] mode;
   logic [W-1:0]   clr;
   logic [W-1:0]   sig_filt;
   logic [W-1:0]   edge_pulse;
   logic [W-1:0]   edge_sticky;

   modport master (
      output sig_in, mode, clr,
      input  sig_filt, edge_pulse, edge_sticky
   );

   modport slave (
      input  sig_in, mode, clr,
      output sig_filt, edge_pulse, edge_sticky
   );
endinterface

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one channel: synchroniser, glitch filter, edge detect, sticky flag
module edge_chan
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   edge_detector_multi_if.slave ch
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   pulse_q, pulse_d;
   logic                   sticky_q, sticky_d;
   logic                   sync_out;
   logic                   differ;
   logic                   accept;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // A change is accepted on the FILTER_LEN-th consecutive disagreeing sample.
   always_comb begin
      differ   = (sync_out != filt_q);
      accept   = differ && (cnt_q == CNT_LAST);
      cnt_d    = '0;
      filt_d   = filt_q;
      pulse_d  = 1'b0;
      sticky_d = sticky_q;
      if (differ && !accept) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (accept) begin
         filt_d  = ~filt_q;
         pulse_d = mode_allows(ch.mode, ~filt_q);
      end
      if (pulse_q) begin
         sticky_d = 1'b1;
      end else if (ch.clr[0]) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         filt_q   <= 1'b0;
         pulse_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], ch.sig_in[0]};
         cnt_q    <= cnt_d;
         filt_q   <= filt_d;
         pulse_q  <= pulse_d;
         sticky_q <= sticky_d;
      end
   end

   assign ch.sig_filt    = filt_q;
   assign ch.edge_pulse  = pulse_q;
   assign ch.edge_sticky = sticky_q;

endmodule

// File: rtl/edge_detector_multi.sv
// rtl/edge_detector_multi.sv - N_CH independent filtered edge detectors with a combined event output
module edge_detector_multi
   import edge_pkg::*;
#(
   parameter int N_CH        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   sig_in,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   clr,
   output logic [N_CH-1:0]   sig_filt,
   output logic [N_CH-1:0]   edge_pulse,
   output logic [N_CH-1:0]   edge_sticky,
   output logic              any_edge
);

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      edge_detector_multi_if #(.W(1)) ch_if ();

      assign ch_if.sig_in   = sig_in[i];
      assign ch_if.mode     = mode[2*i+1:2*i];
      assign ch_if.clr      = clr[i];
      assign sig_filt[i]    = ch_if.sig_filt;
      assign edge_pulse[i]  = ch_if.edge_pulse;
      assign edge_sticky[i] = ch_if.edge_sticky;

      edge_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_chan (
         .clk (clk),
         .rst (rst),
         .ch  (ch_if.slave)
      );
   end

   assign any_edge = |edge_pulse;

endmodule

// File: tb/tb_edge_detector_multi.sv
// tb/tb_edge_detector_multi.sv - self-checking bench for edge_detector_multi
module tb_edge_detector_multi;
   import edge_pkg::*;

   localparam int N = 4;
   localparam int S = 2;
   localparam int F = 4;

   logic clk = 1'b0;
   logic rst;
   logic any_edge;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   edge_detector_multi_if #(.W(N)) bus ();

   edge_detector_multi #(.N_CH(N), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
      .clk         (clk),
      .rst         (rst),
      .sig_in      (bus.sig_in),
      .mode        (bus.mode),
      .clr         (bus.clr),
      .sig_filt    (bus.sig_filt),
      .edge_pulse  (bus.edge_pulse),
      .edge_sticky (bus.edge_sticky),
      .any_edge    (any_edge)
   );

   always #5 clk = ~clk;

   // Reference: a level is accepted once the delayed input has disagreed with it for F samples in a row.
   bit          dl[N][$];
   int          run[N];
   logic [N-1:0] m_filt, m_pulse, m_sticky;

   always @(posedge clk) begin
      logic [N-1:0] p_prev;
      p_prev = m_pulse;
      for (int c = 0; c < N; c++) begin
         bit s;
         int md;
         if (rst) begin
            dl[c].delete();
            for (int k = 0; k < S; k++) dl[c].push_back(1'b0);
            run[c] = 0;
            m_filt[c] = 1'b0;
            m_pulse[c] = 1'b0;
            m_sticky[c] = 1'b0;
         end else begin
            s = dl[c].pop_front();
            dl[c].push_back(bus.sig_in[c]);
            md = int'((bus.mode >> (2 * c)) & 8'd3);
            if (p_prev[c]) m_sticky[c] = 1'b1;
            else if (bus.clr[c]) m_sticky[c] = 1'b0;
            m_pulse[c] = 1'b0;
            if (s == m_filt[c]) begin
               run[c] = 0;
            end else begin
               run[c]++;
               if (run[c] == F) begin
                  m_filt[c] = s;
                  run[c] = 0;
                  m_pulse[c] = s ? (md == 1 || md == 3) : (md == 2 || md == 3);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.sig_in = '0;
      bus.mode = '0;
      bus.clr = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.sig_in = '1;
      bus.mode = '1;
      bus.clr = '0;
      tick();
      total_cnt++; if (bus.sig_filt !== 4'b0) $display("FAIL reset_filt: got %b want 0000", bus.sig_filt); else pass_cnt++;
      total_cnt++; if (bus.edge_pulse !== 4'b0) $display("FAIL reset_pulse: got %b want 0000", bus.edge_pulse); else pass_cnt++;
      total_cnt++; if (bus.edge_sticky !== 4'b0) $display("FAIL reset_sticky: got %b want 0000", bus.edge_sticky); else pass_cnt++;
      total_cnt++; if (any_edge !== 1'b0) $display("FAIL reset_any: got %b want 0", any_edge); else pass_cnt++;
      do_reset();
   endtask

   task automatic test_rise();
      do_reset();
      bus.mode = 8'b0000_0001;
      bus.sig_in = 4'b0001;
      for (int e = 1; e <= 7; e++) begin
         logic ef, ep, es;
         tick();
         ef = (e >= 6);
         ep = (e == 6);
         es = (e >= 7);
         total_cnt++; if (bus.sig_filt[0] !== ef) $display("FAIL rise_filt e%0d: got %b want %b", e, bus.sig_filt[0], ef); else pass_cnt++;
         total_cnt++; if (bus.edge_pulse[0] !== ep) $display("FAIL rise_pulse e%0d: got %b want %b", e, bus.edge_pulse[0], ep); else pass_cnt++;
         total_cnt++; if (any_edge !== ep) $display("FAIL rise_any e%0d: got %b want %b", e, any_edge, ep); else pass_cnt++;
         total_cnt++; if (bus.edge_sticky[0] !== es) $display("FAIL rise_sticky e%0d: got %b want %b", e, bus.edge_sticky[0], es); else pass_cnt++;
      end
   endtask

   task automatic test_glitch();
      do_reset();
      bus.mode = 8'b0000_0011;
      bus.sig_in = 4'b0001;
      tick(); tick(); tick();
      bus.sig_in = 4'b0000;
      for (int e = 0; e < 10; e++) begin
         tick();
         total_cnt++; if (bus.sig_filt[0] !== 1'b0) $display("FAIL glitch_filt e%0d: got %b want 0", e, bus.sig_filt[0]); else pass_cnt++;
         total_cnt++; if (bus.edge_pulse !== 4'b0) $display("FAIL glitch_pulse e%0d: got %b want 0000", e, bus.edge_pulse); else pass_cnt++;
      end
   endtask

   task automatic test_fall_only();
      int rise_pulses = 0;
      int fall_pulses = 0;
      do_reset();
      bus.mode = 8'b0000_1000;
      bus.sig_in = 4'b0010;
      for (int e = 0; e < 10; e++) begin
         tick();
         rise_pulses += int'(bus.edge_pulse[1]);
      end
      total_cnt++; if (bus.sig_filt[1] !== 1'b1) $display("FAIL fall_track_rise: got %b want 1", bus.sig_filt[1]); else pass_cnt++;
      total_cnt++; if (rise_pulses != 0) $display("FAIL fall_no_rise_pulse: got %0d want 0", rise_pulses); else pass_cnt++;
      bus.sig_in = 4'b0000;
      for (int e = 0; e < 10; e++) begin
         tick();
         fall_pulses += int'(bus.edge_pulse[1]);
      end
      total_cnt++; if (bus.sig_filt[1] !== 1'b0) $display("FAIL fall_track_fall: got %b want 0", bus.sig_filt[1]); else pass_cnt++;
      total_cnt++; if (fall_pulses != 1) $display("FAIL fall_one_pulse: got %0d want 1", fall_pulses); else pass_cnt++;
   endtask

   task automatic test_clr_priority();
      do_reset();
      bus.mode = 8'b0011_0000;
      bus.sig_in = 4'b0100;
      repeat (6) tick();
      total_cnt++; if (bus.edge_pulse[2] !== 1'b1) $display("FAIL clr_pulse: got %b want 1", bus.edge_pulse[2]); else pass_cnt++;
      bus.clr = 4'b0100;
      tick();
      total_cnt++; if (bus.edge_sticky[2] !== 1'b1) $display("FAIL clr_set_priority: got %b want 1", bus.edge_sticky[2]); else pass_cnt++;
      tick();
      total_cnt++; if (bus.edge_sticky[2] !== 1'b0) $display("FAIL clr_alone: got %b want 0", bus.edge_sticky[2]); else pass_cnt++;
      bus.clr = 4'b0000;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.mode = 8'b1100_0100;
      bus.sig_in = 4'b0010;
      repeat (7) tick();
      total_cnt++; if (bus.edge_sticky[1] !== 1'b1) $display("FAIL rmid_pre_sticky: got %b want 1", bus.edge_sticky[1]); else pass_cnt++;
      bus.sig_in = 4'b1010;
      repeat (4) tick();
      rst = 1'b1;
      bus.sig_in = 4'b0000;
      tick();
      total_cnt++; if ({bus.sig_filt, bus.edge_pulse, bus.edge_sticky, any_edge} !== 13'b0)
         $display("FAIL rmid_outputs: got %b/%b/%b/%b want all 0", bus.sig_filt, bus.edge_pulse, bus.edge_sticky, any_edge); else pass_cnt++;
      rst = 1'b0;
      for (int e = 0; e < 12; e++) begin
         tick();
         total_cnt++; if (bus.edge_pulse !== 4'b0 || bus.sig_filt !== 4'b0)
            $display("FAIL rmid_aborted e%0d: got pulse %b filt %b want 0000", e, bus.edge_pulse, bus.sig_filt); else pass_cnt++;
      end
   endtask

   task automatic test_held_through_reset();
      rst = 1'b1;
      bus.sig_in = 4'b0001;
      bus.mode = 8'b0000_0001;
      bus.clr = '0;
      tick(); tick();
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         logic ep;
         tick();
         ep = (e == 6);
         total_cnt++; if (bus.edge_pulse[0] !== ep) $display("FAIL held_pulse e%0d: got %b want %b", e, bus.edge_pulse[0], ep); else pass_cnt++;
      end
   endtask

   task automatic test_mode_off();
      do_reset();
      bus.mode = 8'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc % 10 == 0) bus.sig_in[0] = ~bus.sig_in[0];
         tick();
         total_cnt++; if (bus.edge_pulse[0] !== 1'b0 || bus.edge_sticky[0] !== 1'b0 || any_edge !== 1'b0)
            $display("FAIL off_quiet c%0d: got pulse %b sticky %b any %b want 0", cyc, bus.edge_pulse[0], bus.edge_sticky[0], any_edge); else pass_cnt++;
         if (cyc % 10 == 9) begin
            total_cnt++; if (bus.sig_filt[0] !== bus.sig_in[0]) $display("FAIL off_follow c%0d: got %b want %b", cyc, bus.sig_filt[0], bus.sig_in[0]); else pass_cnt++;
         end
      end
   endtask

   task automatic test_random();
      int hold[N];
      do_reset();
      for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 9);
      bus.mode = 8'($urandom);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 49) == 0) bus.mode = 8'($urandom);
         for (int c = 0; c < N; c++) begin
            if (hold[c] == 0) begin
               bus.sig_in[c] = ~bus.sig_in[c];
               hold[c] = $urandom_range(1, 9);
            end else begin
               hold[c]--;
            end
            bus.clr[c] = ($urandom_range(0, 15) == 0);
         end
         tick();
         total_cnt++; if (bus.sig_filt !== m_filt) $display("FAIL rnd_filt c%0d: got %b want %b", cyc, bus.sig_filt, m_filt); else pass_cnt++;
         total_cnt++; if (bus.edge_pulse !== m_pulse) $display("FAIL rnd_pulse c%0d: got %b want %b", cyc, bus.edge_pulse, m_pulse); else pass_cnt++;
         total_cnt++; if (bus.edge_sticky !== m_sticky) $display("FAIL rnd_sticky c%0d: got %b want %b", cyc, bus.edge_sticky, m_sticky); else pass_cnt++;
         total_cnt++; if (any_edge !== (|m_pulse)) $display("FAIL rnd_any c%0d: got %b want %b", cyc, any_edge, |m_pulse); else pass_cnt++;
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.sig_in = '0;
      bus.mode = '0;
      bus.clr = '0;
      test_reset();
      test_rise();
      test_glitch();
      test_fall_only();
      test_clr_priority();
      test_reset_mid();
      test_held_through_reset();
      test_mode_off();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
